// File: rtl/srt4_div_ctrl_if.sv
// srt4_div_ctrl_if
//   Operand/result handshake bundle for the radix-4 SRT divider sequencer.
//   master : operand producer / result consumer (drives in_valid, dividend,
//            divisor, out_ready)
//   slave  : the sequencer (drives in_ready, out_valid, quotient, remainder,
//            div_by_zero)
// Parameter WIDTH : operand width in bits.
interface srt4_div_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/srt4_div_ctrl.sv
// srt4_div_ctrl
//   Sequencer for an iterative unsigned radix-4 SRT divider. Normalises the
//   divisor, feeds an external quotient-digit selection table (funtable) with
//   divisor/partial-remainder estimates, accumulates digits on the fly,
//   corrects the last digit and returns floor(x/d) and x mod d.
// Ports
//   clk, rst   : clock, synchronous active-high reset
//   bus        : srt4_div_ctrl_if.slave operand/result handshake
//   tbl_b      : top 4 bits of the normalised divisor (1.bbb, 8..15)
//   tbl_p      : truncated 4w estimate, signed, 3 int + 2 frac bits
//   tbl_q      : selected digit from the table, signed -2..+2
//   err        : sticky table/bound error
// Build option
//   SRT4_TBL_CHECK_EN : when defined, err flags illegal digit codes and
//   residuals that leave |w| <= (2/3)d_n during ITER. Otherwise err is 0.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// NORM  | normalise divisor, load residual, clear digit registers
// ITER  | K digit-selection cycles
// CORR  | fix last negative digit, scale quotient, form remainder
// DONE  | result presented until out_ready
module srt4_div_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   srt4_div_ctrl_if.slave        bus,
   output logic [3:0]            tbl_b,
   output logic [5:0]            tbl_p,
   input  logic [2:0]            tbl_q,
   output logic                  err
);

   localparam int K  = WIDTH / 2 + 2;
   localparam int RW = WIDTH + 4;
   localparam int SW = $clog2(WIDTH);
   localparam int HW = $clog2(WIDTH + 2);
   localparam int CW = $clog2(K + 1);

   typedef enum logic [2:0] {IDLE, NORM, ITER, CORR, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] x_r;
   logic [WIDTH-1:0] d_r;
   logic [WIDTH-1:0] dn_r;
   logic [HW-1:0]    sh_r;
   logic [RW-1:0]    w_r;
   logic [RW-1:0]    q_r;
   logic [RW-1:0]    qm_r;
   logic [CW-1:0]    cnt_r;

   logic [SW-1:0]    s_c;
   logic [RW-1:0]    dnx;
   logic [RW-1:0]    qd;
   logic [RW-1:0]    w_next;
   logic [RW-1:0]    base;
   logic [RW-1:0]    q_next;
   logic [RW-1:0]    qm_next;
   logic [RW-1:0]    qf;
   logic [WIDTH-1:0] qt;
   logic [WIDTH-1:0] rem_c;

   function automatic logic [SW-1:0] lzc(input logic [WIDTH-1:0] v);
      logic [SW-1:0] n;
      logic          found;
      n     = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + SW'(1);
         end
      end
      return n;
   endfunction

   // The residual w carries WIDTH+2 fraction bits: with d_n read as 1.xxx
   // (unit 2^-(WIDTH-1)), x/8 lands exactly on the integer x, so the dividend
   // is loaded without losing bits. 4w of the top six residual bits then
   // reads as sign + 3 int + 2 frac.
   assign tbl_b = dn_r[WIDTH-1 -: 4];
   assign tbl_p = w_r[RW-1 -: 6];

   always_comb begin
      s_c  = lzc(d_r);
      dnx  = {1'b0, dn_r, 3'b000};
      qd   = '0;
      case (tbl_q)
         3'b000: qd = '0;
         3'b001: qd = dnx;
         3'b010: qd = dnx << 1;
         3'b011: qd = dnx + (dnx << 1);
         3'b100: qd = -(dnx << 2);
         3'b101: qd = -(dnx + (dnx << 1));
         3'b110: qd = -(dnx << 1);
         3'b111: qd = -dnx;
         default: qd = '0;
      endcase
      w_next  = {w_r[RW-3:0], 2'b00} - qd;
      // On-the-fly conversion: for q>=0 the new digit q, for q<0 the digit
      // 4+q; in both cases that is just the low two bits of tbl_q. QM is
      // always Q-1.
      base    = tbl_q[2] ? qm_r : q_r;
      q_next  = {base[RW-3:0], tbl_q[1:0]};
      qm_next = q_next - RW'(1);
      qf      = w_r[RW-1] ? qm_r : q_r;
      qt      = WIDTH'(qf >> sh_r);
      rem_c   = x_r - qt * d_r;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         bus.in_ready    <= 1'b1;
         bus.out_valid   <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
         bus.div_by_zero <= 1'b0;
         x_r             <= '0;
         d_r             <= '0;
         dn_r            <= '0;
         sh_r            <= '0;
         w_r             <= '0;
         q_r             <= '0;
         qm_r            <= '0;
         cnt_r           <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  x_r          <= bus.dividend;
                  d_r          <= bus.divisor;
                  bus.in_ready <= 1'b0;
                  state        <= NORM;
               end
            end
            NORM: begin
               dn_r  <= d_r << s_c;
               sh_r  <= HW'(WIDTH + 1) - HW'(s_c);
               w_r   <= {4'b0000, x_r};
               q_r   <= '0;
               qm_r  <= '0;
               cnt_r <= CW'(K - 1);
               // A zero divisor skips the iterations; CORR loads the fixed
               // result so out_valid follows the accept by two cycles.
               state <= (d_r == '0) ? CORR : ITER;
            end
            ITER: begin
               w_r   <= w_next;
               q_r   <= q_next;
               qm_r  <= qm_next;
               cnt_r <= cnt_r - CW'(1);
               if (cnt_r == '0) state <= CORR;
            end
            CORR: begin
               if (d_r == '0) begin
                  bus.quotient    <= '1;
                  bus.remainder   <= x_r;
                  bus.div_by_zero <= 1'b1;
               end else begin
                  bus.quotient    <= qt;
                  bus.remainder   <= rem_c;
                  bus.div_by_zero <= 1'b0;
               end
               bus.out_valid <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               bus.in_ready  <= 1'b1;
               bus.out_valid <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

`ifdef SRT4_TBL_CHECK_EN
   // Bound check runs on a residual wide enough that a bad digit cannot wrap
   // an out-of-range value back into range.
   localparam int XW = WIDTH + 10;

   logic [XW-1:0] chk_fw;
   logic [XW-1:0] chk_dn;
   logic [XW-1:0] chk_qd;
   logic [XW-1:0] chk_w;
   logic [XW-1:0] chk_mag;
   logic          chk_bad;

   always_comb begin
      chk_fw = {{4{w_r[RW-1]}}, w_r, 2'b00};
      chk_dn = {7'b0000000, dn_r, 3'b000};
      chk_qd = '0;
      case (tbl_q)
         3'b000: chk_qd = '0;
         3'b001: chk_qd = chk_dn;
         3'b010: chk_qd = chk_dn << 1;
         3'b011: chk_qd = chk_dn + (chk_dn << 1);
         3'b100: chk_qd = -(chk_dn << 2);
         3'b101: chk_qd = -(chk_dn + (chk_dn << 1));
         3'b110: chk_qd = -(chk_dn << 1);
         3'b111: chk_qd = -chk_dn;
         default: chk_qd = '0;
      endcase
      chk_w   = chk_fw - chk_qd;
      chk_mag = chk_w[XW-1] ? -chk_w : chk_w;
      chk_bad = (chk_mag + (chk_mag << 1)) > (chk_dn << 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (state == ITER &&
                   ((tbl_q inside {3'b011, 3'b100, 3'b101}) || chk_bad)) begin
         err <= 1'b1;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule
